// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one req/ack data-memory transaction per access.
// Store data is aligned into byte lanes on issue. Load data is extracted and extended on completion.
module mem_lsu #(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              mem_valid,
  input  logic              mem_is_write_dmem,
  input  logic              mem_is_read_dmem,
  input  logic [7:0]        mem_write_width,
  input  logic              mem_load_unsigned,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [63:0]       mem_dmem_write_data,
  output logic              mem_stall,
  output logic              mem_load_valid,
  output logic [63:0]       mem_load_data,
  output logic              mem_misalign,
  output logic              mem_bus_err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [7:0]        dmem_wstrb,
  output logic [63:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [63:0]       dmem_rdata
);

  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] wait_cnt_r;
  logic [2:0]       off_r;
  logic [7:0]       size_r;
  logic             uns_r;
  logic             access_s;
  logic             misalign_s;
  logic             stall_s;

  // Low address bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] align_bits(input logic [7:0] size);
    case (size)
      8'h01:   align_bits = 3'b000;
      8'h03:   align_bits = 3'b001;
      8'h0F:   align_bits = 3'b011;
      8'hFF:   align_bits = 3'b111;
      default: align_bits = 3'b111;
    endcase
  endfunction

  function automatic logic [63:0] extract_load(input logic [63:0] rdata, input logic [2:0] off,
                                               input logic [7:0] size, input logic uns);
    logic [63:0] sh;
    logic [63:0] keep;
    logic        sign;
    sh = rdata >> {off, 3'b000};
    for (int i = 0; i < 8; i++) begin
      keep[8*i +: 8] = {8{size[i]}};
    end
    case (size)
      8'h01:   sign = sh[7];
      8'h03:   sign = sh[15];
      8'h0F:   sign = sh[31];
      8'hFF:   sign = sh[63];
      default: sign = 1'b0;
    endcase
    extract_load = (sh & keep) | ({64{sign & ~uns}} & ~keep);
  endfunction

  // Access qualification and stall, decided combinationally from the presented instruction.
  always_comb begin
    access_s   = 1'b0;
    misalign_s = 1'b0;
    stall_s    = 1'b0;
    if ((state_r == IDLE) && mem_valid && (mem_is_read_dmem || mem_is_write_dmem)) begin
      if ((mem_addr[2:0] & align_bits(mem_write_width)) != 3'b000) begin
        misalign_s = 1'b1;
      end else begin
        access_s = 1'b1;
      end
    end else begin
      access_s   = 1'b0;
      misalign_s = 1'b0;
    end
    case (state_r)
      IDLE:    stall_s = access_s;
      BUSY:    stall_s = 1'b1;
      DONE:    stall_s = 1'b0;
      default: stall_s = 1'b0;
    endcase
  end

  assign mem_stall    = stall_s;
  assign mem_misalign = misalign_s;

  // Transaction FSM with registered bus and result outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r        <= IDLE;
      wait_cnt_r     <= '0;
      off_r          <= 3'b000;
      size_r         <= 8'h00;
      uns_r          <= 1'b0;
      mem_load_valid <= 1'b0;
      mem_load_data  <= 64'h0;
      mem_bus_err    <= 1'b0;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wstrb     <= 8'h00;
      dmem_wdata     <= 64'h0;
    end else begin
      mem_load_valid <= 1'b0;
      mem_bus_err    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (access_s) begin
            state_r    <= BUSY;
            wait_cnt_r <= '0;
            off_r      <= mem_addr[2:0];
            size_r     <= mem_write_width;
            uns_r      <= mem_load_unsigned;
            dmem_req   <= 1'b1;
            dmem_we    <= mem_is_write_dmem;
            dmem_addr  <= {mem_addr[ADDR_W-1:3], 3'b000};
            dmem_wstrb <= mem_write_width << mem_addr[2:0];
            dmem_wdata <= mem_dmem_write_data << {mem_addr[2:0], 3'b000};
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            state_r  <= DONE;
            if (!dmem_we) begin
              mem_load_data  <= extract_load(dmem_rdata, off_r, size_r, uns_r);
              mem_load_valid <= 1'b1;
            end else begin
              mem_load_valid <= 1'b0;
            end
          end else if (wait_cnt_r == CNT_W'(MAX_WAIT - 1)) begin
            // Timeout abort: the pipeline sees a zero load result plus the error pulse.
            dmem_req       <= 1'b0;
            state_r        <= DONE;
            mem_load_data  <= 64'h0;
            mem_load_valid <= 1'b1;
            mem_bus_err    <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule
